serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_if.sv | 52 +++++
 rtl/serial_adder.sv | 159 +++++++++++++++
 tb/tb_serial_adder.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle for the digit-serial adder.
//
//   start  - request, taken only while the adder is idle
//   a, b   - WIDTH-bit operands, captured on the accepting edge
//   cin    - carry-in, captured on the accepting edge
//   sub    - subtract select (present only with SERIAL_ADDER_SUB_EN)
//   busy   - operation in flight (RUN or DONE)
//   done   - one-cycle result-valid pulse
//   s      - WIDTH-bit sum, held until the next result or reset
//   cout   - carry-out of bit WIDTH-1 (for subtract: 1 = no borrow)
//
// Modports: master drives the request side, slave (the adder) drives results.
// Optional feature macro: SERIAL_ADDER_SUB_EN.

interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (
    output start, a, b, cin, sub,
    input  busy, done, s, cout
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, s, cout
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, s, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, s, cout
  );
`endif

endinterface

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder. Adds DIGIT bits per clock, LSB slice first,
// so a WIDTH-bit sum takes N = WIDTH/DIGIT RUN cycles followed by one DONE cycle.
//
// Parameters:
//   WIDTH - operand/result width in bits
//   DIGIT - bits added per clock; WIDTH must be an integer multiple of DIGIT
//
// Ports:
//   clk    - single clock, all state on the rising edge
//   rst_n  - asynchronous active-low reset; aborts any operation in flight
//   bus    - serial_adder_if slave modport (start/a/b/cin[/sub] in,
//            busy/done/s/cout out)
//
// Timing: the accepting edge moves IDLE->RUN, RUN lasts exactly N edges, the
// edge processing the last slice enters DONE and writes s/cout, and DONE lasts
// one cycle. Back-to-back throughput is one result every N+2 cycles.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN adds bus.sub. With sub=1 the
// adder computes a - b by latching ~b, ignoring cin and preloading carry=1;
// cout=1 then means no borrow.

module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int unsigned N    = WIDTH / DIGIT;
  // Sized to hold 0..N so the counter can never wrap inside an operation.
  localparam int unsigned CntW = $clog2(N + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              cout_q, cout_d;

  // One slice of the addition: DIGIT operand bits plus the running carry.
  logic [DIGIT:0]    slice_sum;
  logic [WIDTH-1:0]  a_shift;
  logic [WIDTH-1:0]  b_shift;
  // Full sum as it would look if this slice were the last one.
  logic [WIDTH-1:0]  sum_cat;

  assign slice_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} +
                     {{DIGIT{1'b0}}, carry_q};

  if (N == 1) begin : gen_single
    // Whole word in one slice: no partial-sum storage, operands never shift.
    assign sum_cat = slice_sum[DIGIT-1:0];
    assign a_shift = a_q;
    assign b_shift = b_q;
  end else begin : gen_multi
    // Partial sum of the first N-1 slices. New slices enter at the top and
    // move down, so after N-1 steps slice 0 sits at the LSB and the final
    // slice completes the word in sum_cat without another shift.
    logic [WIDTH-DIGIT-1:0] sum_q;

    assign sum_cat = {slice_sum[DIGIT-1:0], sum_q};
    assign a_shift = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
    assign b_shift = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
      end else if (state_q == StRun) begin
        sum_q <= sum_cat[WIDTH-1:DIGIT];
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d   = bus.a;
          cnt_d = '0;
`ifdef SERIAL_ADDER_SUB_EN
          // a - b == a + ~b + 1; cin has no meaning for a subtract.
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
`else
          b_d     = bus.b;
          carry_d = bus.cin;
`endif
          state_d = StRun;
        end
      end

      StRun: begin
        a_d     = a_shift;
        b_d     = b_shift;
        carry_d = slice_sum[DIGIT];
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          // Results change only here, so s/cout hold between operations.
          s_d     = sum_cat;
          cout_d  = slice_sum[DIGIT];
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);
  assign bus.s    = s_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: four instances (DIGIT = 1, 2, 4, 8 at WIDTH = 8) share
// operands and have individual start lines. Expected results and acceptance
// cycles are queued per instance when a request is driven and popped when that
// instance pulses done.

module tb_serial_adder;

  localparam int unsigned W        = 8;
  localparam int unsigned NUM      = 4;
  localparam int unsigned NUM_RAND = 2500;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [NUM-1:0]   start_v = '0;
  logic [W-1:0]     op_a = '0;
  logic [W-1:0]     op_b = '0;
  logic             op_cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic             op_sub = 1'b0;
`endif
  logic [NUM-1:0]   busy_v;
  logic [NUM-1:0]   done_v;
  logic [NUM-1:0]   cout_v;
  logic [W-1:0]     s_v [NUM];

  int unsigned      cyc = 0;
  int               n_tests = 0;
  int               n_fail  = 0;
  bit               mon_en  = 1'b0;

  typedef struct {
    logic [W:0]  res;
    int unsigned acc_cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W:0]   res;
  } vec_t;

  exp_t       sb_q [NUM][$];
  logic [W:0] last_res [NUM];
  vec_t       vecs [10];

  for (genvar g = 0; g < NUM; g++) begin : gen_dut
    serial_adder_if #(.WIDTH(W)) bus ();

    assign bus.start = start_v[g];
    assign bus.a     = op_a;
    assign bus.b     = op_b;
    assign bus.cin   = op_cin;
`ifdef SERIAL_ADDER_SUB_EN
    assign bus.sub   = op_sub;
`endif
    assign busy_v[g] = bus.busy;
    assign done_v[g] = bus.done;
    assign cout_v[g] = bus.cout;
    assign s_v[g]    = bus.s;

    serial_adder #(
      .WIDTH(W),
      .DIGIT(1 << g)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned n_of(input int g);
    return W >> g;
  endfunction

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result monitor: done pops the scoreboard; otherwise s/cout must hold.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n) begin
      for (int g = 0; g < NUM; g++) begin
        if (done_v[g]) begin
          if (sb_q[g].size() == 0) begin
            check($sformatf("spurious done d%0d", g), {{W{1'b0}}, done_v[g]}, '0);
          end else begin
            e = sb_q[g].pop_front();
            check($sformatf("result d%0d", g), {cout_v[g], s_v[g]}, e.res);
            check_int($sformatf("latency d%0d", g), int'(cyc), int'(e.acc_cyc + n_of(g)));
            last_res[g] = e.res;
          end
        end else begin
          check($sformatf("hold d%0d", g), {cout_v[g], s_v[g]}, last_res[g]);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [NUM-1:0] mask, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin, input logic [W:0] res);
    op_a    = a;
    op_b    = b;
    op_cin  = cin;
    start_v = mask;
    for (int g = 0; g < NUM; g++) begin
      if (mask[g]) sb_q[g].push_back('{res: res, acc_cyc: cyc + 1});
    end
    @(posedge clk);
    #1 start_v = '0;
    @(negedge clk);
    for (int g = 0; g < NUM; g++) begin
      check($sformatf("busy after accept d%0d", g), {{W{1'b0}}, busy_v[g]},
            {{W{1'b0}}, mask[g]});
    end
  endtask

  // Waits (bounded) for every instance to go idle. With scramble set, the
  // operands change and start is pulsed on busy instances every cycle.
  task automatic wait_idle(input bit scramble);
    bit idle = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (busy_v == '0) begin
        idle = 1'b1;
        break;
      end
      if (scramble) begin
        op_a    = W'($urandom);
        op_b    = W'($urandom);
        op_cin  = 1'($urandom);
        start_v = busy_v & NUM'($urandom);
      end
      @(negedge clk);
    end
    start_v = '0;
    check("idle within bound", {{W{1'b0}}, idle}, 9'h001);
  endtask

  initial begin
    int unsigned k;
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   rr;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 9'h100};
    vecs[1] = '{8'h3C, 8'h5A, 1'b1, 9'h097};
    vecs[2] = '{8'h01, 8'h01, 1'b0, 9'h002};
    vecs[3] = '{8'h10, 8'h20, 1'b0, 9'h030};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 9'h100};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 9'h001};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 9'h080};
    vecs[8] = '{8'h0F, 8'h01, 1'b0, 9'h010};
    vecs[9] = '{8'hAA, 8'h55, 1'b1, 9'h100};

    for (int g = 0; g < NUM; g++) last_res[g] = '0;

    // Reset state, before any clock edge.
    #3;
    for (int g = 0; g < NUM; g++) begin
      check($sformatf("reset sum d%0d", g), {cout_v[g], s_v[g]}, '0);
      check($sformatf("reset busy/done d%0d", g), {{(W-1){1'b0}}, busy_v[g], done_v[g]}, '0);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Table of vectors, operands scrambled while each is in flight.
    for (int i = 0; i < 10; i++) begin
      issue('1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].res);
      wait_idle(1'b1);
    end

    // start held high: second request taken on the first IDLE edge after DONE.
    k = cyc + 1;
    op_a = 8'h01; op_b = 8'h01; op_cin = 1'b0;
    start_v = '1;
    for (int g = 0; g < NUM; g++) begin
      sb_q[g].push_back('{res: 9'h002, acc_cyc: k});
      sb_q[g].push_back('{res: 9'h030, acc_cyc: k + n_of(g) + 2});
    end
    @(posedge clk);
    @(negedge clk);
    op_a = 8'h10; op_b = 8'h20;
    for (int t = 0; t < 14; t++) begin
      for (int g = 0; g < NUM; g++) begin
        if (cyc == k + n_of(g) + 2) start_v[g] = 1'b0;
      end
      @(negedge clk);
    end
    start_v = '0;
    wait_idle(1'b0);

    // Reset at RUN edge 3: aborts the wide-N instances, no done afterwards.
    issue('1, 8'hAA, 8'h55, 1'b0, 9'h0FF);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    for (int g = 0; g < NUM; g++) begin
      sb_q[g].delete();
      last_res[g] = '0;
    end
    #1;
    for (int g = 0; g < NUM; g++) begin
      check($sformatf("async reset sum d%0d", g), {cout_v[g], s_v[g]}, '0);
      check($sformatf("async reset busy/done d%0d", g),
            {{(W-1){1'b0}}, busy_v[g], done_v[g]}, '0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue('1, 8'h0F, 8'h01, 1'b0, 9'h010);
    wait_idle(1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    op_sub = 1'b1;
    issue('1, 8'h05, 8'h07, 1'b1, 9'h0FE);
    wait_idle(1'b0);
    issue('1, 8'h07, 8'h05, 1'b0, 9'h102);
    wait_idle(1'b0);
    op_sub = 1'b0;
`endif

    // Random operations against a reference sum.
    for (int i = 0; i < NUM_RAND; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rr = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
`ifdef SERIAL_ADDER_SUB_EN
      op_sub = 1'($urandom);
      if (op_sub) rr = {(ra >= rb), W'(ra - rb)};
`endif
      issue('1, ra, rb, rc, rr);
      wait_idle(1'b1);
`ifdef SERIAL_ADDER_SUB_EN
      op_sub = 1'b0;
`endif
    end

    repeat (3) @(negedge clk);
    for (int g = 0; g < NUM; g++) begin
      check_int($sformatf("outstanding d%0d", g), sb_q[g].size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
